uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
Serial UART transmitter. It takes one parallel byte on a single-cycle start strobe and shifts it out LSB-first as an asynchronous 8N1 frame (start, data, stop) on tx_serial. Bit timing is paced by an externally generated baud_tick, from a shared baud generator. It sits between the host/bus logic and the TX pin, and reports busy and done status.

Parameters:
DATA_BITS, 8, number of data bits per frame (legal 5..8).
STOP_BITS, 1, number of stop bits (legal 1 or 2).

Ports:
clk  input  1  system clock; all logic on its rising edge.
rst  input  1  asynchronous, active-low reset (asserted at 0).
baud_tick  input  1  baud pacing input; a rising edge (0->1 between consecutive clk samples) is one bit-time event.
tx_data  input  DATA_BITS  byte to send; sampled only on start acceptance.
tx_start  input  1  request strobe; one clk wide is sufficient.
tx_serial  output  1  serial line; idle high.
tx_busy  output  1  high while a frame is in progress.
tx_done  output  1  one-clk pulse when a frame completes.

Behaviour:
- Reset (rst=0, async): tx_serial=1, tx_busy=0, tx_done=0, state IDLE, shift register and counters 0, tick-edge register 0.
- Tick event: internal register holds the previous baud_tick; tick_evt = baud_tick & ~prev.
- This works for both single-cycle strobes and square waves. Only one event per rising edge.
- States: IDLE, WAIT, START, DATA, [PARITY], STOP.
- IDLE: tx_serial=1, tx_busy=0.
  - On tx_start=1, latch tx_data into the shift register and go to WAIT.
  - tx_busy=1 from the next clock onward.
- WAIT: tx_serial=1; on tick_evt go to START. This guarantees a full-length start bit.
- START: tx_serial=0; on tick_evt go to DATA with bit index 0.
- DATA: tx_serial = shift[0] (LSB first).
  - On tick_evt, shift right and increment the index.
  - After DATA_BITS bits, go to PARITY if enabled, else STOP.
- STOP: tx_serial=1 for STOP_BITS tick periods. On the tick_evt ending the last stop bit, on that same clock edge:
  - tx_done pulses for exactly 1 clk;
  - tx_busy drops to 0;
  - state returns to IDLE.
- Frame length, acceptance to done: 1 partial (WAIT) + 1 + DATA_BITS + STOP_BITS tick periods (10 full + WAIT for 8N1).
- tx_start while tx_busy=1 is ignored; data is not re-latched.
- tx_start in the same cycle tx_done pulses is ignored. A new request is accepted from the following cycle.
- tx_data changes after acceptance have no effect on the frame in flight.
- tx_serial is registered (glitch-free).
- Reset mid-frame aborts immediately. The line returns high and no tx_done is emitted.
- Ticks while IDLE are ignored.

Optional Feature:
Macro UART_TX_PARITY_EN.
- Defined: after DATA, add a PARITY state. tx_serial = XOR of the latched data bits (even parity) for one tick period, then go to STOP. The frame grows by one bit.
- Undefined: no PARITY state; DATA goes directly to STOP (8N1).

Decomposition:
- Shared package uart_pkg holds:
  - the state enum typedef (IDLE, WAIT, START, DATA, PARITY, STOP);
  - localparam defaults DATA_BITS=8 and STOP_BITS=1;
  - the line idle level constant (1).
- One natural sub-module: uart_tick_edge, the registered rising-edge detector producing tick_evt, reusable by uart_rx.
- The rest is a single FSM plus shift register and counter.

Test Plan:
- Reset: hold rst=0 for 100 ns with baud_tick toggling -> tx_serial=1, tx_busy=0, tx_done=0 throughout.
- Send 0x41: 10 ns clk, baud_tick square wave with 1040 ns half-period; pulse tx_start for 1 clk.
  - Line after WAIT: 0, then 1,0,0,0,0,0,1,0, then 1; each bit lasts 2080 ns.
  - tx_done is a single 1-clk pulse at the end of the stop bit; tx_busy is high the whole frame.
- Send 0x42 back-to-back after 1000 ns idle -> data bits 0,1,0,0,0,0,1,0; one tx_done pulse.
- Assert tx_start mid-frame with tx_data=0xFF -> ignored; frame unchanged; exactly one tx_done.
- Assert rst=0 during the 4th data bit -> tx_serial=1 and tx_busy=0 immediately; no tx_done; the next frame sends correctly.
- With UART_TX_PARITY_EN, send 0x41 -> parity bit 0 before stop; send 0x43 -> parity bit 1.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default frame shape,
// line idle level and the even-parity helper used by the transmitter.
`timescale 1ns/1ps
package uart_pkg;
    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;
    localparam logic LINE_IDLE = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WAIT   = 3'd1,
        START  = 3'd2,
        DATA   = 3'd3,
        PARITY = 3'd4,
        STOP   = 3'd5
    } uart_state_e;

    // Callers zero-extend narrower words, so unused upper bits never flip the result.
    function automatic logic even_parity(input logic [7:0] data);
        return ^data;
    endfunction
endpackage

// File: rtl/uart_tick_edge.sv
// Registered rising-edge detector for the shared baud pacing signal.
// One event per 0->1 transition, whether the tick is a strobe or a square wave.
`timescale 1ns/1ps
module uart_tick_edge (
    input  logic clk,
    input  logic rst,
    input  logic tick_in,
    output logic tick_evt
);
    logic prev_r;

    // Hold the previous tick level so a long high phase yields a single event.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_r <= 1'b0;
        end else begin
            prev_r <= tick_in;
        end
    end

    assign tick_evt = tick_in & ~prev_r;
endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_BITS LSB-first, optional even parity,
// STOP_BITS stop bits. Parity bit is built in when UART_TX_PARITY_EN is defined.
`timescale 1ns/1ps
module uart_tx #(
    parameter int DATA_BITS = uart_pkg::DATA_BITS,
    parameter int STOP_BITS = uart_pkg::STOP_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_tick,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_start,
    output logic                 tx_serial,
    output logic                 tx_busy,
    output logic                 tx_done
);
    import uart_pkg::*;

    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);
    localparam logic LAST_STOP = 1'(STOP_BITS - 1);

    logic                 tick_evt_s;
    uart_state_e          state_r, state_s;
    logic [DATA_BITS-1:0] shift_r, shift_s;
    logic [IDX_W-1:0]     bit_idx_r, bit_idx_s;
    logic                 stop_cnt_r, stop_cnt_s;
    logic                 tx_serial_r, serial_s;
    logic                 tx_busy_r, busy_s;
    logic                 tx_done_r, done_s;
    logic                 parity_bit_s;

    uart_tick_edge u_tick_edge (
        .clk      (clk),
        .rst      (rst),
        .tick_in  (baud_tick),
        .tick_evt (tick_evt_s)
    );

`ifdef UART_TX_PARITY_EN
    logic parity_r, parity_s;

    // Parity is taken from the word at acceptance; the shifter consumes its copy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            parity_r <= 1'b0;
        end else begin
            parity_r <= parity_s;
        end
    end

    assign parity_bit_s = parity_r;
`else
    assign parity_bit_s = LINE_IDLE;
`endif

    // Next-state, shifter and status decisions; every advance is gated by a tick event.
    always_comb begin
        state_s    = state_r;
        shift_s    = shift_r;
        bit_idx_s  = bit_idx_r;
        stop_cnt_s = stop_cnt_r;
        busy_s     = tx_busy_r;
        done_s     = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_s   = parity_r;
`endif
        case (state_r)
            IDLE: begin
                busy_s = 1'b0;
                if (tx_start) begin
                    state_s    = WAIT;
                    shift_s    = tx_data;
                    bit_idx_s  = '0;
                    stop_cnt_s = 1'b0;
                    busy_s     = 1'b1;
`ifdef UART_TX_PARITY_EN
                    parity_s   = even_parity(8'(tx_data));
`endif
                end else begin
                    state_s = IDLE;
                end
            end
            WAIT: begin
                if (tick_evt_s) begin
                    state_s = START;
                end else begin
                    state_s = WAIT;
                end
            end
            START: begin
                if (tick_evt_s) begin
                    state_s   = DATA;
                    bit_idx_s = '0;
                end else begin
                    state_s = START;
                end
            end
            DATA: begin
                if (tick_evt_s) begin
                    shift_s = {1'b0, shift_r[DATA_BITS-1:1]};
                    if (bit_idx_r == LAST_IDX) begin
                        stop_cnt_s = 1'b0;
`ifdef UART_TX_PARITY_EN
                        state_s    = PARITY;
`else
                        state_s    = STOP;
`endif
                    end else begin
                        bit_idx_s = bit_idx_r + 1'b1;
                    end
                end else begin
                    state_s = DATA;
                end
            end
            PARITY: begin
                if (tick_evt_s) begin
                    state_s = STOP;
                end else begin
                    state_s = PARITY;
                end
            end
            STOP: begin
                if (tick_evt_s) begin
                    if (stop_cnt_r == LAST_STOP) begin
                        state_s = IDLE;
                        busy_s  = 1'b0;
                        done_s  = 1'b1;
                    end else begin
                        stop_cnt_s = stop_cnt_r + 1'b1;
                    end
                end else begin
                    state_s = STOP;
                end
            end
            default: begin
                state_s = IDLE;
                busy_s  = 1'b0;
            end
        endcase
    end

    // Line level follows the upcoming state so the pin register moves with the FSM.
    always_comb begin
        case (state_s)
            START:   serial_s = 1'b0;
            DATA:    serial_s = shift_s[0];
            PARITY:  serial_s = parity_bit_s;
            default: serial_s = LINE_IDLE;
        endcase
    end

    // State, datapath and registered outputs; reset aborts any frame with the line high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= IDLE;
            shift_r     <= '0;
            bit_idx_r   <= '0;
            stop_cnt_r  <= 1'b0;
            tx_serial_r <= LINE_IDLE;
            tx_busy_r   <= 1'b0;
            tx_done_r   <= 1'b0;
        end else begin
            state_r     <= state_s;
            shift_r     <= shift_s;
            bit_idx_r   <= bit_idx_s;
            stop_cnt_r  <= stop_cnt_s;
            tx_serial_r <= serial_s;
            tx_busy_r   <= busy_s;
            tx_done_r   <= done_s;
        end
    end

    assign tx_serial = tx_serial_r;
    assign tx_busy   = tx_busy_r;
    assign tx_done   = tx_done_r;
endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: randomized frames compared bit by bit
// against an expected frame built from the 8N1 (optionally 8E1) framing rules.
`timescale 1ns/1ps
module tb_uart_tx;
    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;
    localparam int BIT_NS    = 2080;
`ifdef UART_TX_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    localparam int N_BITS = 1 + DATA_BITS + PAR_BITS + STOP_BITS;

    logic       clk;
    logic       rst;
    logic       baud_tick;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_serial;
    logic       tx_busy;
    logic       tx_done;

    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt = 0;

    uart_tx #(.DATA_BITS(DATA_BITS), .STOP_BITS(STOP_BITS)) dut (
        .clk       (clk),
        .rst       (rst),
        .baud_tick (baud_tick),
        .tx_data   (tx_data),
        .tx_start  (tx_start),
        .tx_serial (tx_serial),
        .tx_busy   (tx_busy),
        .tx_done   (tx_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        baud_tick = 1'b0;
        forever #(BIT_NS / 2) baud_tick = ~baud_tick;
    end

    always @(negedge clk) begin
        if (tx_done === 1'b1) done_cnt <= done_cnt + 1;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Line must stay idle while ticks keep arriving.
    task automatic idle_for(input int ns);
        for (int t = 0; t < ns; t += 100) begin
            #100;
            check("idle_line", tx_serial, 1);
            check("idle_busy", tx_busy, 0);
        end
    endtask

    // mode 0: plain frame, 1: spurious start mid-frame, 2: start coincident with done,
    // 3: reset during the 4th data bit.
    task automatic send_frame(input logic [7:0] data, input int mode);
        int  exp_bits[$];
        int  ones;
        int  done_before;
        bit  seen;
        time t0;
        time t_done;
        exp_bits = {};
        ones = 0;
        exp_bits.push_back(0);
        for (int i = 0; i < DATA_BITS; i++) begin
            exp_bits.push_back(int'((data >> i) & 8'd1));
            ones += int'((data >> i) & 8'd1);
        end
        if (PAR_BITS == 1) exp_bits.push_back(ones % 2);
        for (int i = 0; i < STOP_BITS; i++) exp_bits.push_back(1);

        done_before = done_cnt;
        tx_data  = data;
        tx_start = 1'b1;
        #10;
        tx_start = 1'b0;
        tx_data  = 8'($urandom);
        check("accept_busy", tx_busy, 1);
        check("wait_line", tx_serial, 1);

        seen = 1'b0;
        for (int c = 0; c < 300 && !seen; c++) begin
            #10;
            if (tx_serial === 1'b0) seen = 1'b1;
        end
        check("start_bit_seen", 32'(seen), 1);
        if (!seen) return;
        t0 = $time;

        for (int i = 0; i < N_BITS; i++) begin
            #(t0 + 1040 + i * BIT_NS - $time);
            if (mode == 3 && i == 4) begin
                rst = 1'b0;
                #1;
                check("abort_line", tx_serial, 1);
                check("abort_busy", tx_busy, 0);
                check("abort_done", tx_done, 0);
                #49;
                check("abort_no_done", 32'(done_cnt), 32'(done_before));
                rst = 1'b1;
                return;
            end
            check($sformatf("bit%0d", i), tx_serial, 32'(exp_bits[i]));
            check($sformatf("busy%0d", i), tx_busy, 1);
            if (mode == 1 && i == 3) begin
                tx_data  = 8'hFF;
                tx_start = 1'b1;
                #10;
                tx_start = 1'b0;
            end
        end

        if (mode == 2) begin
            #(t0 + N_BITS * BIT_NS - 10 - $time);
            tx_data  = 8'($urandom);
            tx_start = 1'b1;
            #10;
            check("done_at_edge", tx_done, 1);
            check("busy_drop", tx_busy, 0);
            tx_start = 1'b0;
            #10;
            check("start_at_done_ignored", tx_busy, 0);
            check("done_width", tx_done, 0);
        end else begin
            seen = 1'b0;
            for (int c = 0; c < 300 && !seen; c++) begin
                #10;
                if (tx_done === 1'b1) seen = 1'b1;
            end
            check("done_seen", 32'(seen), 1);
            t_done = $time;
            check("done_time", 32'(t_done - t0), 32'(N_BITS * BIT_NS));
            check("busy_drop", tx_busy, 0);
            check("done_line", tx_serial, 1);
            #10;
            check("done_width", tx_done, 0);
        end
        #10;
        check("done_count", 32'(done_cnt - done_before), 1);
    endtask

    initial begin
        rst      = 1'b0;
        tx_start = 1'b0;
        tx_data  = 8'h00;
        for (int i = 0; i < 5; i++) begin
            #20;
            check("rst_line", tx_serial, 1);
            check("rst_busy", tx_busy, 0);
            check("rst_done", tx_done, 0);
        end
        #1 rst = 1'b1;
        #9;

        idle_for(1000);
        send_frame(8'h41, 0);
        idle_for(1000);
        send_frame(8'h42, 0);
        send_frame(8'h43, 0);
        send_frame(8'($urandom), 1);
        send_frame(8'($urandom), 2);
        send_frame(8'($urandom), 3);
        check("post_abort_line", tx_serial, 1);
        check("post_abort_busy", tx_busy, 0);
        idle_for(300);
        send_frame(8'($urandom), 0);
        for (int k = 0; k < 4; k++) begin
            idle_for(100 * int'($urandom_range(1, 8)));
            send_frame(8'($urandom), int'($urandom_range(0, 2)));
        end
        idle_for(500);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
